// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared UART frame constants, FSM state type and frame builder.
// Revision: 1.0
// ============================================================================
package uart_pkg;

    localparam int   FRAME_W   = 11;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    // Frame as shifted out LSB first: start, data[0..7], parity, stop.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data,
                                                        input logic       parity_odd);
        return {STOP_BIT, (^data) ^ parity_odd, data, START_BIT};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_baud_gen
// Purpose : Free-running divide-by-DIV tick generator with synchronous clear.
// Revision: 1.0
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 5208
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;

    assign tick = run && (r_count == LAST);

    // Counter sits at zero whenever it is not running, so the first tick
    // after a start lands exactly DIV cycles later.
    always_ff @(posedge clk) begin
        if (!reset_n || clear || !run) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_tx_ctrl
// Purpose : UART transmit controller: byte handshake, frame load strobe and
//           bit-period shift ticks for an external 11-bit TxD shift register.
// Revision: 1.0
// ============================================================================
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic               clk_50M,
    input  logic               reset_n,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [FRAME_W-1:0] load,
    output logic               load_en,
    output logic               enable,
    output logic               busy,
    output logic               tx_done
);

    localparam int         DIV      = CLK_HZ / BAUD;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_bit_cnt;
    logic [FRAME_W-1:0] r_load;
    logic               w_accept;
    logic               w_tick;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk     (clk_50M),
        .reset_n (reset_n),
        .clear   (load_en),
        .run     (r_state == SEND),
        .tick    (w_tick)
    );

    always_ff @(posedge clk_50M) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bit counter counts completed bit periods; it stops at FRAME_W.
    always_ff @(posedge clk_50M) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
            r_load    <= '0;
        end else begin
            if (w_accept) begin
                r_bit_cnt <= '0;
                r_load    <= build_frame(tx_data, PARITY_ODD);
            end else if (enable && (r_bit_cnt != 4'(FRAME_W))) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign load = r_load;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        tx_ready    = 1'b0;
        load_en     = 1'b0;
        enable      = 1'b0;
        busy        = 1'b0;
        tx_done     = 1'b0;
        case (r_state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                load_en     = 1'b1;
                busy        = 1'b1;
                w_state_nxt = SEND;
            end
            SEND: begin
                busy   = 1'b1;
                enable = w_tick;
                if (w_tick && (r_bit_cnt == LAST_BIT)) begin
                    tx_done     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_ctrl
// Purpose : Self-checking bench for uart_tx_ctrl (DIV=8 even, default DIV odd).
// Revision: 1.0
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int FDIV = 8;
    localparam int SDIV = 50_000_000 / 9600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Fast instance: DIV = 8, even parity
    logic        reset_n_f = 1'b0;
    logic [7:0]  data_f    = 8'h00;
    logic        valid_f   = 1'b0;
    logic        ready_f, load_en_f, enable_f, busy_f, done_f;
    logic [10:0] load_f;

    // Slow instance: default DIV, odd parity
    logic        reset_n_s = 1'b0;
    logic [7:0]  data_s    = 8'h00;
    logic        valid_s   = 1'b0;
    logic        ready_s, load_en_s, enable_s, busy_s, done_s;
    logic [10:0] load_s;

    uart_tx_ctrl #(.CLK_HZ(8), .BAUD(1), .PARITY_ODD(1'b0)) dut_f (
        .clk_50M (clk),      .reset_n (reset_n_f), .tx_data (data_f),
        .tx_valid(valid_f),  .tx_ready(ready_f),   .load    (load_f),
        .load_en (load_en_f),.enable  (enable_f),  .busy    (busy_f),
        .tx_done (done_f)
    );

    uart_tx_ctrl #(.PARITY_ODD(1'b1)) dut_s (
        .clk_50M (clk),      .reset_n (reset_n_s), .tx_data (data_s),
        .tx_valid(valid_s),  .tx_ready(ready_s),   .load    (load_s),
        .load_en (load_en_s),.enable  (enable_s),  .busy    (busy_s),
        .tx_done (done_s)
    );

    // Downstream TxD shift registers; the line idles high.
    logic [10:0] sr_f = '1;
    logic [10:0] sr_s = '1;
    logic        line_f, line_s;
    always @(posedge clk) begin
        if (!reset_n_f)     sr_f <= '1;
        else if (load_en_f) sr_f <= load_f;
        else if (enable_f)  sr_f <= {1'b1, sr_f[10:1]};
        if (!reset_n_s)     sr_s <= '1;
        else if (load_en_s) sr_s <= load_s;
        else if (enable_s)  sr_s <= {1'b1, sr_s[10:1]};
    end
    assign line_f = sr_f[0];
    assign line_s = sr_s[0];

    function automatic logic [10:0] exp_frame(input logic [7:0] d, input bit odd);
        int          ones;
        logic [10:0] f;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(d[i]);
            f[i+1] = d[i];
        end
        f[9]  = ((ones % 2) == 1) ^ odd;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chki(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Exclusivity and enable-only-while-busy, every cycle on both instances
    always @(negedge clk) begin
        chk1("excl_f", load_en_f && enable_f, 1'b0);
        chk1("excl_s", load_en_s && enable_s, 1'b0);
        chk1("en_idle_f", enable_f && !busy_f, 1'b0);
        chk1("en_idle_s", enable_s && !busy_s, 1'b0);
    end

    // Entered at a negedge with the fast DUT in IDLE; returns at the negedge
    // of the first IDLE cycle after the frame.
    task automatic frame_fast(input logic [7:0] d, input bit keep);
        logic [10:0] f;
        f = exp_frame(d, 1'b0);
        chk1("ready_before", ready_f, 1'b1);
        data_f  = d;
        valid_f = 1'b1;
        @(negedge clk);
        chk1("load_en", load_en_f, 1'b1);
        chkw("load", load_f, f);
        chk1("busy_load", busy_f, 1'b1);
        if (!keep) valid_f = 1'b0;
        for (int n = 1; n <= 11*FDIV; n++) begin
            @(negedge clk);
            chk1("enable", enable_f, (n % FDIV) == 0);
            chk1("tx_done", done_f, n == 11*FDIV);
            chk1("busy", busy_f, 1'b1);
            chk1("ready_send", ready_f, 1'b0);
            chk1("load_en_send", load_en_f, 1'b0);
            chkw("load_hold", load_f, f);
            if ((n % FDIV) == 0) chk1("line_bit", line_f, f[n/FDIV-1]);
            if (keep) data_f = 8'($urandom);
        end
        @(negedge clk);
        chk1("ready_after", ready_f, 1'b1);
        chk1("busy_after", busy_f, 1'b0);
        chk1("line_idle", line_f, 1'b1);
        chk1("enable_after", enable_f, 1'b0);
    endtask

    initial begin
        int last;
        int pulses;

        // Reset with a byte offered: no handshake may be taken
        data_f  = 8'hA5;
        valid_f = 1'b1;
        repeat (2) @(negedge clk);
        chk1("rst_ready", ready_f, 1'b1);
        chk1("rst_load_en", load_en_f, 1'b0);
        chk1("rst_enable", enable_f, 1'b0);
        chk1("rst_busy", busy_f, 1'b0);
        chk1("rst_done", done_f, 1'b0);
        chkw("rst_load", load_f, 11'h000);
        valid_f   = 1'b0;
        reset_n_f = 1'b1;
        reset_n_s = 1'b1;
        repeat (2) @(negedge clk);
        chk1("idle_line", line_f, 1'b1);

        frame_fast(8'h55, 1'b0);
        chkw("load_55", load_f, 11'h4AA);
        frame_fast(8'h01, 1'b0);
        chkw("load_01_even", load_f, 11'h602);

        // Held tx_valid with churning data, back-to-back frames
        frame_fast(8'($urandom), 1'b1);
        frame_fast(8'($urandom), 1'b1);
        frame_fast(8'($urandom), 1'b0);

        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            frame_fast(8'($urandom), 1'b0);
        end

        // Reset for one cycle at the 5th enable
        data_f  = 8'hC3;
        valid_f = 1'b1;
        @(negedge clk);
        chk1("mid_load_en", load_en_f, 1'b1);
        valid_f = 1'b0;
        repeat (5*FDIV) @(negedge clk);
        chk1("mid_enable5", enable_f, 1'b1);
        reset_n_f = 1'b0;
        @(negedge clk);
        chk1("mid_busy", busy_f, 1'b0);
        chk1("mid_ready", ready_f, 1'b1);
        chk1("mid_enable", enable_f, 1'b0);
        chk1("mid_done", done_f, 1'b0);
        chkw("mid_load", load_f, 11'h000);
        reset_n_f = 1'b1;
        for (int n = 0; n < 8*FDIV; n++) begin
            @(negedge clk);
            chk1("post_rst_enable", enable_f, 1'b0);
            chk1("post_rst_done", done_f, 1'b0);
            chk1("post_rst_busy", busy_f, 1'b0);
        end
        frame_fast(8'($urandom), 1'b0);

        // Default divider, odd parity
        data_s  = 8'h01;
        valid_s = 1'b1;
        @(negedge clk);
        chk1("s_load_en", load_en_s, 1'b1);
        chkw("s_load_model", load_s, exp_frame(8'h01, 1'b1));
        chkw("s_load_01_odd", load_s, 11'h402);
        valid_s = 1'b0;
        last    = 0;
        pulses  = 0;
        for (int n = 1; n <= 11*SDIV + 1; n++) begin
            @(negedge clk);
            if (enable_s) begin
                pulses++;
                chki("s_spacing", n - last, SDIV);
                if (pulses <= 11) chk1("s_line_bit", line_s, load_s[pulses-1]);
                last = n;
            end
            if (done_s || n == 11*SDIV) chk1("s_done", done_s, n == 11*SDIV);
        end
        chki("s_pulses", pulses, 11);
        chk1("s_ready_after", ready_s, 1'b1);
        chk1("s_line_idle", line_s, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller that sits directly upstream of the 11-bit TxD shift register. It accepts bytes over a valid/ready handshake and builds the 11-bit frame: start, 8 data bits LSB first, parity, stop. It issues a one-cycle load strobe to the shift register, then generates the per-bit shift tick (9600 Hz at 50 MHz). It counts the 11 bit periods and reports completion.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = CLK_HZ/BAUD, integer truncation (5208 at defaults); DIV >= 2 required
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
clk_50M  in  1  system clock, rising edge
reset_n  in  1  synchronous active-low reset
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  controller can accept a byte
load  out  11  frame to shift register: {1'b1 stop, parity, tx_data[7:0], 1'b0 start}
load_en  out  1  one-cycle frame load strobe
enable  out  1  one-cycle bit-period tick to shift register
busy  out  1  frame in progress (LOAD or SEND)
tx_done  out  1  one-cycle pulse at end of stop bit

Behaviour:
- Reset: synchronous, checked on every rising edge while reset_n = 0, and has priority over all other inputs.
- Reset values: state = IDLE, baud counter = 0, bit counter = 0, load = 0, load_en = 0, enable = 0, busy = 0, tx_done = 0.
- tx_ready = (state == IDLE). It reads 1 during reset, but no handshake is taken while reset_n = 0.
- Reset mid-frame: the frame is abandoned, with no tx_done and no further enable pulses. The controller is in IDLE on the first cycle after reset_n rises.
- State IDLE:
  - tx_valid && tx_ready at edge T: capture tx_data, go to LOAD.
  - Parity p = (^tx_data) ^ PARITY_ODD.
  - load is registered with the frame at that same edge.
- State LOAD (the cycle after T):
  - load_en = 1 for exactly this cycle; busy = 1.
  - Baud counter held at 0, bit counter = 0.
  - Next state SEND.
- State SEND:
  - Baud counter increments each cycle.
  - When the counter equals DIV-1: enable = 1 for that cycle, counter wraps to 0, bit counter increments.
  - First enable occurs DIV cycles after the load_en cycle. The k-th enable occurs at (load_en cycle + k*DIV), for k = 1..11.
  - On the 11th enable: tx_done = 1 in the same cycle, next state IDLE. Stop bit has then been held one full period.
- Frame timing:
  - Frame length = 11*DIV cycles from the cycle after load_en.
  - Minimum byte-to-byte spacing is 11*DIV + 2 cycles (one LOAD cycle, one IDLE accept cycle).
- Exclusivity: load_en and enable are never high in the same cycle. enable is never high outside SEND.
- tx_valid and tx_data are ignored while tx_ready = 0. A byte held on tx_valid across a frame is accepted again in the next IDLE cycle; dropping tx_valid is the producer's job.
- load holds the last frame value until the next acceptance; the shift register samples it only on load_en.
- busy = 1 in LOAD and SEND, 0 in IDLE.
- Counter widths:
  - baud counter = $clog2(DIV) bits.
  - bit counter = 4 bits, range 0..11, never wraps past 11.

Decomposition:
- Shared package uart_pkg holds:
  - FRAME_W = 11, START_BIT = 1'b0, STOP_BIT = 1'b1
  - state enum {IDLE, LOAD, SEND}
  - function build_frame(data, parity_odd) returning the 11-bit frame.
- One sub-module, uart_baud_gen:
  - Counts to DIV-1 with a synchronous clear input and a tick output.
  - Used here with clear = load_en; reusable later by the receiver.

Test Plan:
- Even-parity byte 0x55 (four ones, p = 0), DIV = 8 (CLK_HZ = 8, BAUD = 1): accept at T → load_en at T+1 with load = 11'h4AA. enable at T+9, T+17, …, T+89 (11 pulses); tx_done at T+89; tx_ready back to 1 at T+90.
- Odd-ones byte 0x01, PARITY_ODD = 0: load = 11'h602 (parity bit 1). Same byte with PARITY_ODD = 1: load = 11'h402.
- Held tx_valid with changing tx_data during SEND: no acceptance and load unchanged until IDLE. The next frame's load_en lands exactly 2 cycles after the previous tx_done.
- reset_n low for one cycle at the 5th enable: no further enable pulses, no tx_done, busy = 0. The first cycle after release is IDLE, and a new byte is accepted normally.
- Default parameters: DIV = 5208; enable spacing measured as exactly 5208 cycles; 11 pulses per frame; load_en and enable never coincide, checked by assertion throughout.
- Shift register connected: serial output reconstructs start 0, data LSB first, parity, stop 1. The line stays 1 after tx_done.
